// File: rtl/im_loader_if.sv
// Loader bus: session control, byte stream handshake, instruction-memory
// write port and status.
//   master : the side that requests sessions and supplies program bytes
//   slave  : im_loader
//   start/len_words        session request and word count
//   byte_in/valid/ready    byte stream; a transfer happens on valid & ready
//   im_we/im_add/im_din    instruction-memory write port
//   busy/done/word_cnt/err session status
interface im_loader_if;
  logic        start;
  logic [10:0] len_words;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        im_we;
  logic [9:0]  im_add;
  logic [31:0] im_din;
  logic        busy;
  logic        done;
  logic [10:0] word_cnt;
  logic        err;

  modport master (
    output start, len_words, byte_in, byte_valid,
    input  byte_ready, im_we, im_add, im_din, busy, done, word_cnt, err
  );

  modport slave (
    input  start, len_words, byte_in, byte_valid,
    output byte_ready, im_we, im_add, im_din, busy, done, word_cnt, err
  );
endinterface

// File: rtl/im_loader.sv
// Instruction-memory loader. Gathers a byte stream into 32-bit words and
// writes each word to consecutive word addresses starting at 0.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : im_loader_if.slave (control, byte stream, memory port, status)
// Parameters:
//   NWORDS     : largest session length accepted (1..1024)
//   BIG_ENDIAN : 1 = first byte of a word goes to im_din[31:24], 0 = [7:0]
module im_loader #(
  parameter int NWORDS     = 1024,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  im_loader_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t      state, state_nx;
  logic [10:0] len_q;
  logic [10:0] cnt_q;
  logic [1:0]  bidx;
  logic [31:0] asm_q, asm_nx;
  logic [31:0] din_q;
  logic        err_q;
  logic        xfer;
  logic        len_ok;

  assign xfer   = bus.byte_valid && bus.byte_ready;
  assign len_ok = (bus.len_words != 11'd0) && (bus.len_words <= 11'(NWORDS));

  // Word being assembled with the current byte dropped into its slot.
  always_comb begin
    asm_nx = asm_q;
    if (BIG_ENDIAN)
      asm_nx[8*(3-int'(bidx)) +: 8] = bus.byte_in;
    else
      asm_nx[8*int'(bidx) +: 8] = bus.byte_in;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.start && len_ok) state_nx = RECV;
      RECV:  if (xfer && bidx == 2'd3) state_nx = WRITE;
      WRITE: state_nx = (cnt_q + 11'd1 == len_q) ? DONE : RECV;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
      bidx  <= '0;
      asm_q <= '0;
      din_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (bus.start) begin
          if (len_ok) begin
            len_q <= bus.len_words;
            cnt_q <= '0;
            bidx  <= '0;
            err_q <= 1'b0;
          end else begin
            err_q <= 1'b1;
          end
        end
        RECV: if (xfer) begin
          asm_q <= asm_nx;
          bidx  <= bidx + 2'd1;
          // Output word only changes here so im_din stays stable between writes.
          if (bidx == 2'd3) din_q <= asm_nx;
        end
        WRITE: cnt_q <= cnt_q + 11'd1;
        default: ;
      endcase
      // A request arriving mid-session is flagged but otherwise ignored.
      if (state != IDLE && bus.start) err_q <= 1'b1;
    end
  end

  assign bus.byte_ready = (state == RECV);
  assign bus.im_we      = (state == WRITE);
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.im_add     = cnt_q[9:0];
  assign bus.im_din     = din_q;
  assign bus.word_cnt   = cnt_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: directed and randomized sessions on a
// big-endian instance, a short check on a little-endian instance.
module tb_im_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  im_loader_if bif();
  im_loader_if lif();

  im_loader #(.NWORDS(1024), .BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bif.slave));
  im_loader #(.NWORDS(1024), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst), .bus(lif.slave));

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] bytes[$];
  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every write must match the next expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (bif.im_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %h data %h, none expected", bif.im_add, bif.im_din);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_addr", 32'(bif.im_add), 32'(mon_e.addr));
          chk("write_data", bif.im_din, mon_e.data);
          chk("ready_in_write", 32'(bif.byte_ready), 32'd0);
        end
      end
      if (bif.done) done_cnt++;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bif.start = 1'b0; bif.len_words = '0; bif.byte_in = '0; bif.byte_valid = 1'b0;
    lif.start = 1'b0; lif.len_words = '0; lif.byte_in = '0; lif.byte_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic pulse_start(input logic [10:0] len);
    bif.start = 1'b1;
    bif.len_words = len;
    @(posedge clk); #1;
    bif.start = 1'b0;
  endtask

  // Returns 0 if the loader never became ready.
  task automatic send_byte(input logic [7:0] b, input bit st, output bit ok);
    int tmo = 0;
    bif.byte_in = b;
    bif.byte_valid = 1'b1;
    if (st) bif.start = 1'b1;
    while (!bif.byte_ready && tmo < 20) begin
      @(posedge clk); #1;
      tmo++;
    end
    ok = (tmo < 20);
    if (ok) begin
      @(posedge clk); #1;
    end
    bif.byte_valid = 1'b0;
    bif.start = 1'b0;
  endtask

  // Runs a session over the bytes queue; model pushes expected writes.
  task automatic run_session(input int len, input int gap_pct, input bit mid_start,
                             input bit exp_err);
    int d0;
    bit ok;
    for (int k = 0; k < len; k++) begin
      wr_t w;
      w.addr = 10'(k);
      w.data = (32'(bytes[4*k]) << 24) | (32'(bytes[4*k+1]) << 16) |
               (32'(bytes[4*k+2]) << 8) | 32'(bytes[4*k+3]);
      exp_q.push_back(w);
    end
    d0 = done_cnt;
    pulse_start(11'(len));
    chk("busy_after_start", 32'(bif.busy), 32'd1);
    for (int i = 0; i < 4*len; i++) begin
      if ($urandom_range(99) < gap_pct) begin
        int g = $urandom_range(3, 1);
        repeat (g) begin @(posedge clk); #1; end
      end
      send_byte(bytes[i], mid_start && i == 5, ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL byte_ready_timeout: byte %0d never accepted", i);
        exp_q.delete();
        return;
      end
      if (i % 4 == 3) chk("we_after_4th_byte", 32'(bif.im_we), 32'd1);
    end
    @(posedge clk); #1;
    chk("done_pulse", 32'(bif.done), 32'd1);
    chk("word_cnt", 32'(bif.word_cnt), 32'(len));
    chk("err_flag", 32'(bif.err), 32'(exp_err));
    @(posedge clk); #1;
    chk("busy_after_done", 32'(bif.busy), 32'd0);
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("all_writes_seen", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit ok;
    logic [7:0] le_b[4];
    le_b = '{8'h04, 8'h00, 8'h01, 8'h8C};

    do_reset();
    chk("rst_byte_ready", 32'(bif.byte_ready), 32'd0);
    chk("rst_im_we", 32'(bif.im_we), 32'd0);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_done", 32'(bif.done), 32'd0);
    chk("rst_err", 32'(bif.err), 32'd0);
    chk("rst_word_cnt", 32'(bif.word_cnt), 32'd0);
    chk("rst_im_add", 32'(bif.im_add), 32'd0);
    chk("rst_im_din", bif.im_din, 32'd0);

    // Single word, back-to-back bytes.
    bytes = '{8'h8C, 8'h01, 8'h00, 8'h04};
    run_session(1, 0, 1'b0, 1'b0);

    // Two words with random gaps.
    bytes = '{8'h8C, 8'h02, 8'h00, 8'h08, 8'h00, 8'h22, 8'h18, 8'h21};
    run_session(2, 50, 1'b0, 1'b0);

    // Illegal lengths set err and do nothing else.
    pulse_start(11'd0);
    chk("len0_err", 32'(bif.err), 32'd1);
    chk("len0_busy", 32'(bif.busy), 32'd0);
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_session(1, 0, 1'b0, 1'b0);
    pulse_start(11'd1025);
    chk("len1025_err", 32'(bif.err), 32'd1);
    chk("len1025_busy", 32'(bif.busy), 32'd0);
    repeat (3) @(posedge clk); #1;

    // start pulsed mid-session.
    bytes.delete();
    repeat (12) bytes.push_back(8'($urandom));
    run_session(3, 30, 1'b1, 1'b1);

    // Random sessions.
    for (int s = 0; s < 5; s++) begin
      int len = $urandom_range(6, 1);
      bytes.delete();
      repeat (4*len) bytes.push_back(8'($urandom));
      run_session(len, 30, 1'b0, 1'b0);
    end

    // Reset mid-word: partial word discarded, next session restarts at 0.
    pulse_start(11'd2);
    send_byte(8'hAA, 1'b0, ok);
    send_byte(8'hBB, 1'b0, ok);
    do_reset();
    chk("midrst_busy", 32'(bif.busy), 32'd0);
    chk("midrst_word_cnt", 32'(bif.word_cnt), 32'd0);
    bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_session(1, 0, 1'b0, 1'b0);

    // Full-size session ends at address 0x3FF.
    bytes.delete();
    repeat (4096) bytes.push_back(8'($urandom));
    run_session(1024, 0, 1'b0, 1'b0);

    // Little-endian instance.
    lif.start = 1'b1; lif.len_words = 11'd1;
    @(posedge clk); #1;
    lif.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lif.byte_in = le_b[i];
      lif.byte_valid = 1'b1;
      @(posedge clk); #1;
    end
    lif.byte_valid = 1'b0;
    chk("le_we", 32'(lif.im_we), 32'd1);
    chk("le_din", lif.im_din, 32'h8C010004);
    chk("le_add", 32'(lif.im_add), 32'd0);
    @(posedge clk); #1;
    chk("le_done", 32'(lif.done), 32'd1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter NWORDS, default 1024; maximum number of words per load session (1..1024).
REQ-002 Parameter BIG_ENDIAN, default 1; 1 = first received byte lands in im_din[31:24], 0 = in im_din[7:0].
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to begin a load session; sampled only in IDLE.
REQ-006 len_words  input  11  number of words to load; sampled with an accepted start.
REQ-007 byte_in  input  8  incoming program byte.
REQ-008 byte_valid  input  1  byte_in holds a valid byte.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs on byte_valid & byte_ready.
REQ-010 im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 im_add  output  10  word address, drives instruction-memory address bits [11:2].
REQ-012 im_din  output  32  assembled instruction word.
REQ-013 busy  output  1  session in progress; also holds the CPU out of fetch.
REQ-014 done  output  1  one-cycle pulse after the final word is written.
REQ-015 word_cnt  output  11  words written in the current or last session.
REQ-016 err  output  1  sticky error flag.

Function
REQ-017 FSM states: IDLE, RECV, WRITE, DONE.
REQ-018 IDLE: byte_ready=0, busy=0, im_we=0; start with 1 <= len_words <= NWORDS moves to RECV next cycle, latches len_words, clears word_cnt, byte index and err.
REQ-019 IDLE: start with len_words=0 or len_words > NWORDS sets err=1 and remains in IDLE with no write.
REQ-020 RECV: byte_ready=1, busy=1; each transfer shifts byte_in into the assembler at the slot set by BIG_ENDIAN and byte index (0..3), then increments the byte index.
REQ-021 RECV: the transfer of byte index 3 moves to WRITE next cycle and resets the byte index to 0; byte_valid without byte_ready has no effect.
REQ-022 WRITE: im_we=1 for exactly one cycle, im_add=word_cnt[9:0], im_din=assembled word, byte_ready=0.
REQ-023 On leaving WRITE, word_cnt increments; state becomes DONE if the new word_cnt equals the latched length, else RECV.
REQ-024 DONE: done=1 for one cycle, busy=1, byte_ready=0; then IDLE.
REQ-025 Latency: the 4th byte is accepted in cycle N, im_we is asserted in N+1, and done (if last word) in N+2; minimum 5 cycles per word.
REQ-026 start outside IDLE is ignored for control and sets err=1; the session continues unaffected.
REQ-027 im_add never exceeds NWORDS-1; no address wrap occurs within a session.
REQ-028 im_we=0 in all states except WRITE; im_din holds its last value outside WRITE.

Reset
REQ-029 rst (synchronous) forces state IDLE, byte_ready=0, im_we=0, busy=0, done=0, err=0, word_cnt=0, im_add=0, im_din=0, byte index=0.
REQ-030 rst mid-session discards any partially assembled word; no write is issued, and the next session starts at im_add=0.
REQ-031 rst has priority over start and byte transfers in the same cycle.

Verification
REQ-032 start, len=1, bytes 8C,01,00,04 back-to-back (BIG_ENDIAN=1) -> single im_we at im_add=0, im_din=0x8C010004; done pulses next cycle; word_cnt=1.
REQ-033 len=2, bytes 8C,02,00,08,00,22,18,21 with random byte_valid gaps -> writes 0x8C020008 @0 and 0x00221821 @1; byte_ready=0 during each WRITE.
REQ-034 BIG_ENDIAN=0, len=1, bytes 04,00,01,8C -> im_din=0x8C010004.
REQ-035 start with len=0, and separately len=1025 -> err=1, busy=0, im_we never asserts.
REQ-036 start pulsed mid-session -> err=1; session completes with correct words and a single done.
REQ-037 rst after 2 bytes of word 0, then new session len=1 -> no write before rst; new word written at im_add=0; len=1024 run ends with last write at im_add=0x3FF, word_cnt=1024.
